axi_rd_mux_rr: RTL and testbench

//  AXI read-data (R) channel crossbar return path, generalised to NUM_S slaves and NUM_M masters.

---
 rtl/axi_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 45 ++++
 rtl/axi_rd_mux_rr.sv | 175 +++++++++++++++++
 tb/tb_axi_rd_mux_rr.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI defaults, RRESP codes and the read-mux FSM state type.
package axi_pkg;
  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_DATA_BITS = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} rd_mux_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first requester at or after the pointer.
// The pointer moves to the slot after the current owner on an upd strobe.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         upd,
  input  logic [N-1:0] cur,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int  k;
    logic found;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_q) + i;
      if (k >= N) k = k - N;
      if (en && !found && req[k]) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd) begin
      for (int i = 0; i < N; i++)
        if (cur[i]) ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
endmodule

// File: rtl/axi_rd_mux_rr.sv
// AXI R-channel return mux: round-robin slave arbitration, grant locked per burst,
// one-hot master routing from the upper RID bits, bad selects drained to a sink.
module axi_rd_mux_rr
  import axi_pkg::*;
#(
  parameter int NUM_S     = 3,
  parameter int NUM_M     = 2,
  parameter int ID_BITS   = AXI_ID_BITS,
  parameter int IDS_BITS  = AXI_IDS_BITS,
  parameter int DATA_BITS = AXI_DATA_BITS,
  parameter bit REG_OUT   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_S*IDS_BITS-1:0]  RID_S,
  input  logic [NUM_S*DATA_BITS-1:0] RDATA_S,
  input  logic [NUM_S*2-1:0]         RRESP_S,
  input  logic [NUM_S-1:0]           RLAST_S,
  input  logic [NUM_S-1:0]           RVALID_S,
  output logic [NUM_S-1:0]           RREADY_S,
  output logic [ID_BITS-1:0]         RID_M,
  output logic [DATA_BITS-1:0]       RDATA_M,
  output logic [1:0]                 RRESP_M,
  output logic                       RLAST_M,
  output logic [NUM_M-1:0]           RVALID_M,
  input  logic [NUM_M-1:0]           RREADY_M,
  output logic                       drop_pulse
);
  rd_mux_state_e state_q, state_d;
  logic [NUM_S-1:0] gnt_q, gnt_d, arb_gnt;

  logic [IDS_BITS-1:0]  sel_id;
  logic [DATA_BITS-1:0] sel_data;
  logic [1:0]           sel_resp;
  logic                 sel_last, sel_vld;
  logic [NUM_M-1:0]     msel;
  logic                 msel_ok, vld_s, tgt_rdy, slv_rdy, rel;

  // Grant is one-hot, so an OR-reduction acts as the slave mux.
  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    sel_resp = '0;
    sel_last = 1'b0;
    sel_vld  = 1'b0;
    for (int s = 0; s < NUM_S; s++) begin
      if (gnt_q[s]) begin
        sel_id   = sel_id   | RID_S[s*IDS_BITS +: IDS_BITS];
        sel_data = sel_data | RDATA_S[s*DATA_BITS +: DATA_BITS];
        sel_resp = sel_resp | RRESP_S[s*2 +: 2];
        sel_last = sel_last | RLAST_S[s];
        sel_vld  = sel_vld  | RVALID_S[s];
      end
    end
  end

  generate
    if (IDS_BITS > ID_BITS + NUM_M) begin : g_id_hi
      logic id_hi_unused;
      assign id_hi_unused = ^sel_id[IDS_BITS-1:ID_BITS+NUM_M];
    end
  endgenerate

  assign msel    = sel_id[ID_BITS +: NUM_M];
  assign msel_ok = (msel != '0) && ((msel & (msel - NUM_M'(1))) == '0);
  assign vld_s   = (state_q == BURST) && sel_vld;
  assign rel     = slv_rdy & sel_last;

  rr_arbiter #(.N(NUM_S)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (RVALID_S),
    .en  (state_q == IDLE),
    .upd (rel),
    .cur (gnt_q),
    .gnt (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: if (|RVALID_S) begin
        state_d = BURST;
        gnt_d   = arb_gnt;
      end
      BURST: if (rel) begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Bad selects are always accepted so a stray burst can never wedge the lock.
  always_comb begin
    drop_pulse = vld_s & ~msel_ok;
    slv_rdy    = drop_pulse | (vld_s & msel_ok & tgt_rdy);
    RREADY_S   = gnt_q & {NUM_S{slv_rdy}};
  end

  generate
    if (REG_OUT) begin : g_reg
      logic                 ov_q, ov_d, olast_q, olast_d, drain, acc;
      logic [ID_BITS-1:0]   oid_q, oid_d;
      logic [DATA_BITS-1:0] odata_q, odata_d;
      logic [1:0]           oresp_q, oresp_d;
      logic [NUM_M-1:0]     omsel_q, omsel_d;

      assign drain   = ov_q & |(omsel_q & RREADY_M);
      assign tgt_rdy = ~ov_q | drain;
      assign acc     = vld_s & msel_ok & tgt_rdy;

      always_comb begin
        ov_d    = acc | (ov_q & ~drain);
        oid_d   = acc ? sel_id[ID_BITS-1:0] : oid_q;
        odata_d = acc ? sel_data : odata_q;
        oresp_d = acc ? sel_resp : oresp_q;
        olast_d = acc ? sel_last : olast_q;
        omsel_d = acc ? msel     : omsel_q;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ov_q    <= 1'b0;
          oid_q   <= '0;
          odata_q <= '0;
          oresp_q <= '0;
          olast_q <= 1'b0;
          omsel_q <= '0;
        end else begin
          ov_q    <= ov_d;
          oid_q   <= oid_d;
          odata_q <= odata_d;
          oresp_q <= oresp_d;
          olast_q <= olast_d;
          omsel_q <= omsel_d;
        end
      end

      always_comb begin
        RVALID_M = ov_q ? omsel_q : '0;
        RID_M    = ov_q ? oid_q   : '0;
        RDATA_M  = ov_q ? odata_q : '0;
        RRESP_M  = ov_q ? oresp_q : '0;
        RLAST_M  = ov_q & olast_q;
      end
    end else begin : g_comb
      logic fwd;
      assign fwd     = vld_s & msel_ok;
      assign tgt_rdy = |(msel & RREADY_M);

      always_comb begin
        RVALID_M = fwd ? msel : '0;
        RID_M    = fwd ? sel_id[ID_BITS-1:0] : '0;
        RDATA_M  = fwd ? sel_data : '0;
        RRESP_M  = fwd ? sel_resp : '0;
        RLAST_M  = fwd & sel_last;
      end
    end
  endgenerate
endmodule

// File: tb/tb_axi_rd_mux_rr.sv
// Directed bench: a REG_OUT=0 and a REG_OUT=1 instance share slave/master stimulus.
module tb_axi_rd_mux_rr;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] rid_s;
  logic [95:0] rdata_s;
  logic [5:0]  rresp_s;
  logic [2:0]  rlast_s, rvalid_s;
  logic [1:0]  rready_m;

  logic [2:0]  rready_s0, rready_s1;
  logic [3:0]  rid_m0, rid_m1;
  logic [31:0] rdata_m0, rdata_m1;
  logic [1:0]  rresp_m0, rresp_m1, rvalid_m0, rvalid_m1;
  logic        rlast_m0, rlast_m1, drop0, drop1;

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  axi_rd_mux_rr #(.REG_OUT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .RID_S(rid_s), .RDATA_S(rdata_s), .RRESP_S(rresp_s),
    .RLAST_S(rlast_s), .RVALID_S(rvalid_s), .RREADY_S(rready_s0), .RID_M(rid_m0),
    .RDATA_M(rdata_m0), .RRESP_M(rresp_m0), .RLAST_M(rlast_m0), .RVALID_M(rvalid_m0),
    .RREADY_M(rready_m), .drop_pulse(drop0));

  axi_rd_mux_rr #(.REG_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .RID_S(rid_s), .RDATA_S(rdata_s), .RRESP_S(rresp_s),
    .RLAST_S(rlast_s), .RVALID_S(rvalid_s), .RREADY_S(rready_s1), .RID_M(rid_m1),
    .RDATA_M(rdata_m1), .RRESP_M(rresp_m1), .RLAST_M(rlast_m1), .RVALID_M(rvalid_m1),
    .RREADY_M(rready_m), .drop_pulse(drop1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_s(input int s, input logic v, input logic [7:0] id,
                       input logic [31:0] d, input logic [1:0] r, input logic l);
    rvalid_s[s]       = v;
    rid_s[s*8 +: 8]   = id;
    rdata_s[s*32 +: 32] = d;
    rresp_s[s*2 +: 2] = r;
    rlast_s[s]        = l;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rid_s = '0; rdata_s = '0; rresp_s = '0; rlast_s = '0; rvalid_s = '0; rready_m = '0;
    step();
    step();
    vec++;
    if ({rvalid_m0, rready_s0, drop0, rid_m0, rdata_m0, rresp_m0, rlast_m0} !== '0) begin
      miss++;
      $display("FAIL reset_dut0 got vm=%b rs=%b drop=%b id=%h data=%h", rvalid_m0, rready_s0, drop0, rid_m0, rdata_m0);
    end
    vec++;
    if ({rvalid_m1, rready_s1, drop1, rid_m1, rdata_m1, rresp_m1, rlast_m1} !== '0) begin
      miss++;
      $display("FAIL reset_dut1 got vm=%b rs=%b drop=%b id=%h data=%h", rvalid_m1, rready_s1, drop1, rid_m1, rdata_m1);
    end
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single_burst();
    do_reset();
    rready_m = 2'b01;
    set_s(0, 1'b1, 8'h15, 32'hA000_0000, 2'b00, 1'b0);
    #1;
    vec++;
    if ({rvalid_m0, rready_s0, drop0} !== 6'b00_000_0) begin
      miss++; $display("FAIL single_idle got %b%b%b want 000000", rvalid_m0, rready_s0, drop0);
    end
    step();
    for (int b = 0; b < 4; b++) begin
      set_s(0, 1'b1, 8'h15, 32'hA000_0000 + b, 2'(b), b == 3);
      #1;
      vec++;
      if ({rvalid_m0, rready_s0, drop0, rid_m0, rdata_m0, rresp_m0, rlast_m0} !==
          {2'b01, 3'b001, 1'b0, 4'h5, 32'hA000_0000 + b, 2'(b), b == 3}) begin
        miss++;
        $display("FAIL single_beat%0d got vm=%b rs=%b id=%h data=%h resp=%b last=%b want vm=01 rs=001 id=5 data=%h",
                 b, rvalid_m0, rready_s0, rid_m0, rdata_m0, rresp_m0, rlast_m0, 32'hA000_0000 + b);
      end
      step();
    end
    set_s(0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    #1;
    vec++;
    if ({rvalid_m0, rready_s0, drop0} !== 6'b0) begin
      miss++; $display("FAIL single_done got %b%b%b want 000000", rvalid_m0, rready_s0, drop0);
    end
  endtask

  task automatic test_contention();
    logic [2:0] exp_rs [8];
    exp_rs = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    do_reset();
    rready_m = 2'b01;
    for (int s = 0; s < 3; s++) set_s(s, 1'b1, 8'h15, 32'hC0 + s, 2'b00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #1;
      vec++;
      if ({rready_s0, rvalid_m0} !== {exp_rs[i], (exp_rs[i] != 3'b000) ? 2'b01 : 2'b00}) begin
        miss++; $display("FAIL contention_c%0d got rs=%b vm=%b want rs=%b", i, rready_s0, rvalid_m0, exp_rs[i]);
      end
      step();
    end
    rvalid_s = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_s(1, 1'b1, 8'h2A, 32'hBEEF_0001, 2'b10, 1'b1);
    #1;
    vec++;
    if ({rvalid_m0, rready_s0} !== 5'b0) begin
      miss++; $display("FAIL bp_idle got vm=%b rs=%b", rvalid_m0, rready_s0);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      rready_m = {1'b0, i[0]};
      #1;
      vec++;
      if ({rvalid_m0, rready_s0, drop0, rid_m0, rdata_m0, rresp_m0, rlast_m0} !==
          {2'b10, 3'b000, 1'b0, 4'hA, 32'hBEEF_0001, 2'b10, 1'b1}) begin
        miss++;
        $display("FAIL bp_hold%0d got vm=%b rs=%b id=%h data=%h resp=%b want vm=10 rs=000 id=a data=beef0001 resp=10",
                 i, rvalid_m0, rready_s0, rid_m0, rdata_m0, rresp_m0);
      end
      step();
    end
    rready_m = 2'b10;
    #1;
    vec++;
    if ({rvalid_m0, rready_s0} !== 5'b10_010) begin
      miss++; $display("FAIL bp_release got vm=%b rs=%b want 10 010", rvalid_m0, rready_s0);
    end
    step();
    set_s(1, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    #1;
    vec++;
    if ({rvalid_m0, rready_s0} !== 5'b0) begin
      miss++; $display("FAIL bp_done got vm=%b rs=%b", rvalid_m0, rready_s0);
    end
  endtask

  task automatic test_bad_select();
    do_reset();
    rready_m = 2'b11;
    set_s(0, 1'b1, 8'h35, 32'hD0, 2'b00, 1'b0);
    #1;
    step();
    for (int b = 0; b < 2; b++) begin
      set_s(0, 1'b1, 8'h35, 32'hD0 + b, 2'b00, b == 1);
      #1;
      vec++;
      if ({rvalid_m0, rready_s0, drop0} !== 6'b00_001_1) begin
        miss++; $display("FAIL bad_beat%0d got vm=%b rs=%b drop=%b want 00 001 1", b, rvalid_m0, rready_s0, drop0);
      end
      step();
    end
    set_s(0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    set_s(1, 1'b1, 8'h15, 32'hE1, 2'b00, 1'b1);
    #1;
    vec++;
    if ({rvalid_m0, rready_s0, drop0} !== 6'b0) begin
      miss++; $display("FAIL bad_idle got vm=%b rs=%b drop=%b want all 0", rvalid_m0, rready_s0, drop0);
    end
    step();
    vec++;
    if ({rvalid_m0, rready_s0, drop0, rdata_m0} !== {6'b01_010_0, 32'hE1}) begin
      miss++; $display("FAIL bad_unlock got vm=%b rs=%b drop=%b data=%h want 01 010 0 e1", rvalid_m0, rready_s0, drop0, rdata_m0);
    end
    step();
    set_s(1, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_lock();
    do_reset();
    rready_m = 2'b01;
    set_s(1, 1'b1, 8'h15, 32'hF0, 2'b00, 1'b0);
    #1;
    step();
    vec++;
    if ({rvalid_m0, rready_s0} !== 5'b01_010) begin
      miss++; $display("FAIL lock_beat0 got vm=%b rs=%b want 01 010", rvalid_m0, rready_s0);
    end
    step();
    set_s(1, 1'b0, 8'h15, 32'hF0, 2'b00, 1'b0);
    set_s(0, 1'b1, 8'h15, 32'hF9, 2'b00, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #1;
      vec++;
      if ({rvalid_m0, rready_s0} !== 5'b0) begin
        miss++; $display("FAIL lock_gap%0d got vm=%b rs=%b want 00 000", i, rvalid_m0, rready_s0);
      end
      step();
    end
    set_s(1, 1'b1, 8'h15, 32'hF1, 2'b00, 1'b1);
    #1;
    vec++;
    if ({rvalid_m0, rready_s0, rdata_m0} !== {5'b01_010, 32'hF1}) begin
      miss++; $display("FAIL lock_last got vm=%b rs=%b data=%h want 01 010 f1", rvalid_m0, rready_s0, rdata_m0);
    end
    step();
    set_s(1, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    #1;
    vec++;
    if ({rvalid_m0, rready_s0} !== 5'b0) begin
      miss++; $display("FAIL lock_gapidle got vm=%b rs=%b want 00 000", rvalid_m0, rready_s0);
    end
    step();
    vec++;
    if ({rvalid_m0, rready_s0, rdata_m0} !== {5'b01_001, 32'hF9}) begin
      miss++; $display("FAIL lock_next got vm=%b rs=%b data=%h want 01 001 f9", rvalid_m0, rready_s0, rdata_m0);
    end
    step();
    set_s(0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    rready_m = 2'b01;
    set_s(1, 1'b1, 8'h15, 32'h11, 2'b00, 1'b1);
    #1;
    step();
    vec++;
    if ({rvalid_m1, rready_s1} !== 5'b00_010) begin
      miss++; $display("FAIL reg_accept got vm=%b rs=%b want 00 010", rvalid_m1, rready_s1);
    end
    step();
    set_s(1, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    set_s(0, 1'b1, 8'h15, 32'h22, 2'b00, 1'b0);
    #1;
    vec++;
    if ({rvalid_m1, rready_s1, rdata_m1} !== {5'b01_000, 32'h11}) begin
      miss++; $display("FAIL reg_latency got vm=%b rs=%b data=%h want 01 000 11", rvalid_m1, rready_s1, rdata_m1);
    end
    step();
    rready_m = 2'b00;
    #1;
    vec++;
    if ({rvalid_m1, rready_s1} !== 5'b00_001) begin
      miss++; $display("FAIL reg_s0_accept got vm=%b rs=%b want 00 001", rvalid_m1, rready_s1);
    end
    step();
    vec++;
    if ({rvalid_m1, rready_s1, rdata_m1} !== {5'b01_000, 32'h22}) begin
      miss++; $display("FAIL reg_full got vm=%b rs=%b data=%h want 01 000 22", rvalid_m1, rready_s1, rdata_m1);
    end
    rst = 1'b0;
    #1;
    vec++;
    if ({rvalid_m1, rready_s1, drop1, rid_m1, rdata_m1, rresp_m1, rlast_m1} !== '0) begin
      miss++; $display("FAIL reg_rst_outs got vm=%b rs=%b id=%h data=%h", rvalid_m1, rready_s1, rid_m1, rdata_m1);
    end
    step();
    rst = 1'b1;
    rready_m = 2'b01;
    set_s(0, 1'b1, 8'h15, 32'h33, 2'b00, 1'b1);
    set_s(2, 1'b1, 8'h15, 32'h44, 2'b00, 1'b1);
    #1;
    vec++;
    if ({rvalid_m1, rready_s1} !== 5'b0) begin
      miss++; $display("FAIL reg_restart_idle got vm=%b rs=%b", rvalid_m1, rready_s1);
    end
    step();
    vec++;
    if ({rvalid_m1, rready_s1} !== 5'b00_001) begin
      miss++; $display("FAIL reg_ptr_cleared got vm=%b rs=%b want 00 001", rvalid_m1, rready_s1);
    end
    step();
    set_s(0, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
    #1;
    vec++;
    if ({rvalid_m1, rdata_m1} !== {2'b01, 32'h33}) begin
      miss++; $display("FAIL reg_restart_beat got vm=%b data=%h want 01 33", rvalid_m1, rdata_m1);
    end
    step();
    set_s(2, 1'b0, 8'h00, 32'h0, 2'b00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_contention();
    test_backpressure();
    test_bad_select();
    test_lock();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
